// File: rtl/msrv32_decode_pkg.sv
// Shared encodings and the decoded-instruction bundle layout for the msrv32 decode stage.
// The bundle is a packed struct; the offsets below give each field's LSB position.
package msrv32_decode_pkg;

   localparam logic [6:0] OPCODE_OP       = 7'b0110011;
   localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
   localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
   localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
   localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
   localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;

   localparam logic [2:0] IMM_R   = 3'b000;
   localparam logic [2:0] IMM_I   = 3'b001;
   localparam logic [2:0] IMM_S   = 3'b010;
   localparam logic [2:0] IMM_B   = 3'b011;
   localparam logic [2:0] IMM_U   = 3'b100;
   localparam logic [2:0] IMM_J   = 3'b101;
   localparam logic [2:0] IMM_CSR = 3'b110;

   localparam logic [2:0] WB_ALU     = 3'b000;
   localparam logic [2:0] WB_LOAD    = 3'b001;
   localparam logic [2:0] WB_IMM     = 3'b010;
   localparam logic [2:0] WB_IADDER  = 3'b011;
   localparam logic [2:0] WB_CSR     = 3'b100;
   localparam logic [2:0] WB_PC_PLUS = 3'b101;

   localparam logic [31:0] ECALL_INSTR  = 32'h0000_0073;
   localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
   localparam logic [31:0] MRET_INSTR   = 32'h3020_0073;

   typedef struct packed {
      logic [3:0] alu_opcode;
      logic       is_muldiv;
      logic [2:0] imm_type;
      logic [2:0] wb_mux_sel;
      logic       rf_wr_en;
      logic       csr_wr_en;
      logic [2:0] csr_op;
      logic       mem_wr_req;
      logic [1:0] load_size;
      logic       load_unsigned;
      logic       alu_src;
      logic       iadder_src;
      logic       is_ecall;
      logic       is_ebreak;
      logic       is_mret;
      logic       is_fence;
      logic       illegal_instr;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
   } bundle_t;

   localparam int unsigned BUNDLE_W = $bits(bundle_t);

   localparam int unsigned OFS_RS2           = 0;
   localparam int unsigned OFS_RS1           = 5;
   localparam int unsigned OFS_RD            = 10;
   localparam int unsigned OFS_ILLEGAL_INSTR = 15;
   localparam int unsigned OFS_IS_FENCE      = 16;
   localparam int unsigned OFS_IS_MRET       = 17;
   localparam int unsigned OFS_IS_EBREAK     = 18;
   localparam int unsigned OFS_IS_ECALL      = 19;
   localparam int unsigned OFS_IADDER_SRC    = 20;
   localparam int unsigned OFS_ALU_SRC       = 21;
   localparam int unsigned OFS_LOAD_UNSIGNED = 22;
   localparam int unsigned OFS_LOAD_SIZE     = 23;
   localparam int unsigned OFS_MEM_WR_REQ    = 25;
   localparam int unsigned OFS_CSR_OP        = 26;
   localparam int unsigned OFS_CSR_WR_EN     = 29;
   localparam int unsigned OFS_RF_WR_EN      = 30;
   localparam int unsigned OFS_WB_MUX_SEL    = 31;
   localparam int unsigned OFS_IMM_TYPE      = 34;
   localparam int unsigned OFS_IS_MULDIV     = 37;
   localparam int unsigned OFS_ALU_OPCODE    = 38;

endpackage

// File: rtl/msrv32_decode_stage_if.sv
// Fetch-side and execute-side handshake of the decode stage, plus the flush request.
// The stage itself takes the slave view; fetch/execute (or a bench) take the master view.
interface msrv32_decode_stage_if #(
   parameter int unsigned DEPTH = 2
);
   logic                          flush_in;
   logic                          in_valid_in;
   logic                          in_ready_out;
   logic [31:0]                   instr_in;
   logic [31:0]                   pc_in;
   logic                          out_valid_out;
   logic                          out_ready_in;
   msrv32_decode_pkg::bundle_t    bundle_out;
   logic [31:0]                   pc_out;
   logic [$clog2(DEPTH):0]        count_out;

   modport master (
      output flush_in, in_valid_in, instr_in, pc_in, out_ready_in,
      input  in_ready_out, out_valid_out, bundle_out, pc_out, count_out
   );

   modport slave (
      input  flush_in, in_valid_in, instr_in, pc_in, out_ready_in,
      output in_ready_out, out_valid_out, bundle_out, pc_out, count_out
   );
endinterface

// File: rtl/msrv32_instr_decode.sv
// Purely combinational RV32I(+M) decoder: instruction word to packed control bundle.
// Illegal encodings still produce a bundle, but with all architectural write enables cleared.
module msrv32_instr_decode
   import msrv32_decode_pkg::*;
#(
   parameter bit M_EXT = 1'b1
) (
   input  logic [31:0] instr_in,
   output bundle_t     bundle_out
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       f7_zero;
   logic       f7_alt;
   logic       f7_mul;
   logic       illegal;
   logic       rf_wr;
   logic       csr_wr;
   logic       mem_wr;

   assign opcode  = instr_in[6:0];
   assign funct3  = instr_in[14:12];
   assign funct7  = instr_in[31:25];
   assign f7_zero = (funct7 == 7'b0000000);
   assign f7_alt  = (funct7 == 7'b0100000);
   assign f7_mul  = (funct7 == 7'b0000001);

   always_comb begin
      bundle_out     = '0;
      bundle_out.rd  = instr_in[11:7];
      bundle_out.rs1 = instr_in[19:15];
      bundle_out.rs2 = instr_in[24:20];
      illegal        = 1'b0;
      rf_wr          = 1'b0;
      csr_wr         = 1'b0;
      mem_wr         = 1'b0;

      case (opcode)
         OPCODE_OP: begin
            bundle_out.alu_opcode = {funct7[5], funct3};
            bundle_out.alu_src    = 1'b1;
            bundle_out.imm_type   = IMM_R;
            bundle_out.wb_mux_sel = WB_ALU;
            rf_wr                 = 1'b1;
            if (f7_mul && M_EXT) begin
               bundle_out.is_muldiv = 1'b1;
            end else if (f7_alt) begin
               illegal = !(funct3 == 3'b000 || funct3 == 3'b101);
            end else if (!f7_zero) begin
               illegal = 1'b1;
            end
         end
         OPCODE_OP_IMM: begin
            // Only SRAI carries the arithmetic bit; other immediates reuse funct7 as data.
            bundle_out.alu_opcode = {(funct3 == 3'b101) & funct7[5], funct3};
            bundle_out.imm_type   = IMM_I;
            bundle_out.wb_mux_sel = WB_ALU;
            rf_wr                 = 1'b1;
            if (funct3 == 3'b001) begin
               illegal = !f7_zero;
            end else if (funct3 == 3'b101) begin
               illegal = !(f7_zero || f7_alt);
            end
         end
         OPCODE_LOAD: begin
            bundle_out.imm_type      = IMM_I;
            bundle_out.wb_mux_sel    = WB_LOAD;
            bundle_out.iadder_src    = 1'b1;
            bundle_out.load_size     = funct3[1:0];
            bundle_out.load_unsigned = funct3[2];
            rf_wr                    = 1'b1;
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
         end
         OPCODE_STORE: begin
            bundle_out.imm_type   = IMM_S;
            bundle_out.iadder_src = 1'b1;
            mem_wr                = 1'b1;
            illegal               = (funct3 > 3'b010);
         end
         OPCODE_BRANCH: begin
            bundle_out.imm_type = IMM_B;
            illegal             = (funct3 == 3'b010) || (funct3 == 3'b011);
         end
         OPCODE_JAL: begin
            bundle_out.imm_type   = IMM_J;
            bundle_out.wb_mux_sel = WB_PC_PLUS;
            rf_wr                 = 1'b1;
         end
         OPCODE_JALR: begin
            bundle_out.imm_type   = IMM_I;
            bundle_out.wb_mux_sel = WB_PC_PLUS;
            bundle_out.iadder_src = 1'b1;
            rf_wr                 = 1'b1;
         end
         OPCODE_LUI: begin
            bundle_out.imm_type   = IMM_U;
            bundle_out.wb_mux_sel = WB_IMM;
            rf_wr                 = 1'b1;
         end
         OPCODE_AUIPC: begin
            bundle_out.imm_type   = IMM_U;
            bundle_out.wb_mux_sel = WB_IADDER;
            rf_wr                 = 1'b1;
         end
         OPCODE_MISC_MEM: begin
            bundle_out.is_fence = 1'b1;
         end
         OPCODE_SYSTEM: begin
            bundle_out.imm_type   = IMM_CSR;
            bundle_out.wb_mux_sel = WB_CSR;
            bundle_out.csr_op     = funct3;
            if (funct3 == 3'b000) begin
               bundle_out.is_ecall  = (instr_in == ECALL_INSTR);
               bundle_out.is_ebreak = (instr_in == EBREAK_INSTR);
               bundle_out.is_mret   = (instr_in == MRET_INSTR);
               illegal = !((instr_in == ECALL_INSTR) || (instr_in == EBREAK_INSTR) ||
                           (instr_in == MRET_INSTR));
            end else if (funct3 == 3'b100) begin
               illegal = 1'b1;
            end else begin
               rf_wr  = 1'b1;
               csr_wr = 1'b1;
            end
         end
         // Also catches every opcode whose low two bits are not 11.
         default: illegal = 1'b1;
      endcase

      bundle_out.illegal_instr = illegal;
      bundle_out.rf_wr_en      = rf_wr & ~illegal;
      bundle_out.csr_wr_en     = csr_wr & ~illegal;
      bundle_out.mem_wr_req    = mem_wr & ~illegal;
   end

endmodule

// File: rtl/msrv32_decode_stage.sv
// Registered decode stage: decodes on push and buffers up to DEPTH bundles in a circular queue.
// Outputs are driven from registered state only; flush clears the queue in one cycle.
module msrv32_decode_stage
   import msrv32_decode_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter bit          M_EXT = 1'b1
) (
   input logic                  ms_riscv32_mp_clk_in,
   input logic                  ms_riscv32_mp_rst_n_in,
   msrv32_decode_stage_if.slave bus
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   bundle_t          dec_bundle;
   bundle_t          bundle_mem [DEPTH];
   logic [31:0]      pc_mem     [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push;
   logic             pop;
   logic             in_ready;
   logic             out_valid;

   msrv32_instr_decode #(
      .M_EXT (M_EXT)
   ) u_decode (
      .instr_in   (bus.instr_in),
      .bundle_out (dec_bundle)
   );

   assign in_ready  = (count_q < CNT_W'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = bus.in_valid_in & in_ready & ~bus.flush_in;
   assign pop       = out_valid & bus.out_ready_in & ~bus.flush_in;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (bus.flush_in) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so natural overflow gives the modulo wrap.
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop) begin
            count_d = count_q + 1'b1;
         end else if (pop && !push) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
      if (!ms_riscv32_mp_rst_n_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (push) begin
         bundle_mem[wr_ptr_q] <= dec_bundle;
         pc_mem[wr_ptr_q]     <= bus.pc_in;
      end
   end

   // Gate the storage read so an empty or freshly reset queue shows all-zero outputs.
   assign bus.in_ready_out  = in_ready;
   assign bus.out_valid_out = out_valid;
   assign bus.bundle_out    = out_valid ? bundle_mem[rd_ptr_q] : '0;
   assign bus.pc_out        = out_valid ? pc_mem[rd_ptr_q] : '0;
   assign bus.count_out     = count_q;

endmodule

// File: tb/tb_msrv32_decode_stage.sv
// Directed bench for msrv32_decode_stage: one DEPTH=4/M_EXT=1 instance and one
// DEPTH=2/M_EXT=0 instance sharing clock and reset.
module tb_msrv32_decode_stage;
   import msrv32_decode_pkg::*;

   localparam int F_ALU     = 0;
   localparam int F_IMM     = 1;
   localparam int F_WB      = 2;
   localparam int F_RF_WR   = 3;
   localparam int F_CSR_WR  = 4;
   localparam int F_CSR_OP  = 5;
   localparam int F_MEM_WR  = 6;
   localparam int F_LSIZE   = 7;
   localparam int F_IADDER  = 8;
   localparam int F_ECALL   = 9;
   localparam int F_EBREAK  = 10;
   localparam int F_MRET    = 11;
   localparam int F_FENCE   = 12;
   localparam int F_ILLEGAL = 13;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   always #5 clk = ~clk;

   msrv32_decode_stage_if #(.DEPTH(4)) bus4 ();
   msrv32_decode_stage_if #(.DEPTH(2)) bus2 ();

   msrv32_decode_stage #(
      .DEPTH (4),
      .M_EXT (1'b1)
   ) dut (
      .ms_riscv32_mp_clk_in   (clk),
      .ms_riscv32_mp_rst_n_in (rst_n),
      .bus                    (bus4)
   );

   msrv32_decode_stage #(
      .DEPTH (2),
      .M_EXT (1'b0)
   ) dut_nom (
      .ms_riscv32_mp_clk_in   (clk),
      .ms_riscv32_mp_rst_n_in (rst_n),
      .bus                    (bus2)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] fld(input bundle_t b, input int id);
      case (id)
         F_ALU:     return 32'(b.alu_opcode);
         F_IMM:     return 32'(b.imm_type);
         F_WB:      return 32'(b.wb_mux_sel);
         F_RF_WR:   return 32'(b.rf_wr_en);
         F_CSR_WR:  return 32'(b.csr_wr_en);
         F_CSR_OP:  return 32'(b.csr_op);
         F_MEM_WR:  return 32'(b.mem_wr_req);
         F_LSIZE:   return 32'(b.load_size);
         F_IADDER:  return 32'(b.iadder_src);
         F_ECALL:   return 32'(b.is_ecall);
         F_EBREAK:  return 32'(b.is_ebreak);
         F_MRET:    return 32'(b.is_mret);
         F_FENCE:   return 32'(b.is_fence);
         F_ILLEGAL: return 32'(b.illegal_instr);
         default:   return 32'hdead_beef;
      endcase
   endfunction

   // Push one word into the empty DEPTH=4 queue, check one field of the head, then pop it.
   task automatic dec_vec(input string tag, input logic [31:0] instr, input int id,
                          input logic [31:0] exp);
      bus4.in_valid_in = 1'b1;
      bus4.instr_in    = instr;
      bus4.pc_in       = 32'h0000_0500;
      tick();
      bus4.in_valid_in = 1'b0;
      check(tag, 64'(fld(bus4.bundle_out, id)), 64'(exp));
      bus4.out_ready_in = 1'b1;
      tick();
      bus4.out_ready_in = 1'b0;
   endtask

   initial begin
      bus4.flush_in = 1'b0; bus4.in_valid_in = 1'b0; bus4.out_ready_in = 1'b0;
      bus4.instr_in = '0;   bus4.pc_in = '0;
      bus2.flush_in = 1'b0; bus2.in_valid_in = 1'b0; bus2.out_ready_in = 1'b0;
      bus2.instr_in = '0;   bus2.pc_in = '0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 64'(bus4.out_valid_out), 64'd0);
      check("rst_count", 64'(bus4.count_out), 64'd0);
      check("rst_ready", 64'(bus4.in_ready_out), 64'd1);
      check("rst_bundle", 64'(bus4.bundle_out), 64'd0);
      check("rst_pc", 64'(bus4.pc_out), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // ADDI x1,x2,5
      bus4.in_valid_in = 1'b1; bus4.instr_in = 32'h0051_0093; bus4.pc_in = 32'h0000_0100;
      tick();
      bus4.in_valid_in = 1'b0;
      check("addi_valid", 64'(bus4.out_valid_out), 64'd1);
      check("addi_count", 64'(bus4.count_out), 64'd1);
      check("addi_alu", 64'(bus4.bundle_out.alu_opcode), 64'd0);
      check("addi_imm", 64'(bus4.bundle_out.imm_type), 64'd1);
      check("addi_rf_wr", 64'(bus4.bundle_out.rf_wr_en), 64'd1);
      check("addi_illegal", 64'(bus4.bundle_out.illegal_instr), 64'd0);
      check("addi_rd", 64'(bus4.bundle_out.rd), 64'd1);
      check("addi_rs1", 64'(bus4.bundle_out.rs1), 64'd2);
      check("addi_pc", 64'(bus4.pc_out), 64'h100);
      bus4.out_ready_in = 1'b1;
      tick();
      bus4.out_ready_in = 1'b0;
      check("addi_popped", 64'(bus4.count_out), 64'd0);

      // MUL x3,x1,x2 on both instances
      bus4.in_valid_in = 1'b1; bus4.instr_in = 32'h0220_81B3; bus4.pc_in = 32'h0000_0104;
      bus2.in_valid_in = 1'b1; bus2.instr_in = 32'h0220_81B3; bus2.pc_in = 32'h0000_0104;
      tick();
      bus4.in_valid_in = 1'b0; bus2.in_valid_in = 1'b0;
      check("mul_m1_muldiv", 64'(bus4.bundle_out.is_muldiv), 64'd1);
      check("mul_m1_illegal", 64'(bus4.bundle_out.illegal_instr), 64'd0);
      check("mul_m1_rf_wr", 64'(bus4.bundle_out.rf_wr_en), 64'd1);
      check("mul_m0_illegal", 64'(bus2.bundle_out.illegal_instr), 64'd1);
      check("mul_m0_rf_wr", 64'(bus2.bundle_out.rf_wr_en), 64'd0);
      check("mul_m0_muldiv", 64'(bus2.bundle_out.is_muldiv), 64'd0);
      bus4.out_ready_in = 1'b1; bus2.out_ready_in = 1'b1;
      tick();
      bus4.out_ready_in = 1'b0; bus2.out_ready_in = 1'b0;

      // Fill DEPTH=4 with five offers; the fifth must be refused.
      bus4.instr_in = 32'h0051_0093;
      for (int i = 0; i < 5; i++) begin
         bus4.in_valid_in = 1'b1;
         bus4.pc_in = 32'h200 + 32'(4 * i);
         check($sformatf("fill_ready%0d", i), 64'(bus4.in_ready_out), (i < 4) ? 64'd1 : 64'd0);
         tick();
      end
      bus4.in_valid_in = 1'b0;
      check("full_count", 64'(bus4.count_out), 64'd4);
      check("full_ready", 64'(bus4.in_ready_out), 64'd0);
      check("full_head", 64'(bus4.pc_out), 64'h200);
      tick();
      check("hold_head", 64'(bus4.pc_out), 64'h200);
      bus4.out_ready_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("drain_valid%0d", i), 64'(bus4.out_valid_out), 64'd1);
         check($sformatf("drain_pc%0d", i), 64'(bus4.pc_out), 64'h200 + 64'(4 * i));
         tick();
      end
      bus4.out_ready_in = 1'b0;
      check("drain_empty", 64'(bus4.out_valid_out), 64'd0);
      check("drain_count", 64'(bus4.count_out), 64'd0);

      // Streaming at occupancy 2
      for (int i = 0; i < 2; i++) begin
         bus4.in_valid_in = 1'b1;
         bus4.pc_in = 32'h300 + 32'(4 * i);
         tick();
      end
      for (int i = 0; i < 20; i++) begin
         bus4.in_valid_in  = 1'b1;
         bus4.out_ready_in = 1'b1;
         bus4.pc_in = 32'h308 + 32'(4 * i);
         check($sformatf("stream_count%0d", i), 64'(bus4.count_out), 64'd2);
         check($sformatf("stream_pc%0d", i), 64'(bus4.pc_out), 64'h300 + 64'(4 * i));
         tick();
      end
      bus4.out_ready_in = 1'b0;
      bus4.pc_in = 32'h358;
      check("stream_end_count", 64'(bus4.count_out), 64'd2);
      check("stream_end_pc", 64'(bus4.pc_out), 64'h350);
      tick();
      bus4.in_valid_in = 1'b0;
      check("pre_flush_count", 64'(bus4.count_out), 64'd3);

      // Flush with a simultaneous push
      bus4.flush_in = 1'b1; bus4.in_valid_in = 1'b1; bus4.pc_in = 32'h35C;
      tick();
      bus4.flush_in = 1'b0; bus4.in_valid_in = 1'b0;
      check("flush_count", 64'(bus4.count_out), 64'd0);
      check("flush_valid", 64'(bus4.out_valid_out), 64'd0);
      check("flush_ready", 64'(bus4.in_ready_out), 64'd1);
      bus4.in_valid_in = 1'b1; bus4.pc_in = 32'h400;
      tick();
      bus4.in_valid_in = 1'b0;
      check("post_flush_count", 64'(bus4.count_out), 64'd1);
      check("post_flush_pc", 64'(bus4.pc_out), 64'h400);
      bus4.out_ready_in = 1'b1;
      tick();
      bus4.out_ready_in = 1'b0;

      // Asynchronous reset between edges while pushing
      bus4.in_valid_in = 1'b1; bus4.pc_in = 32'h600;
      tick();
      tick();
      check("pre_rst_count", 64'(bus4.count_out), 64'd2);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 64'(bus4.out_valid_out), 64'd0);
      check("arst_count", 64'(bus4.count_out), 64'd0);
      check("arst_bundle", 64'(bus4.bundle_out), 64'd0);
      check("arst_pc", 64'(bus4.pc_out), 64'd0);
      check("arst_ready", 64'(bus4.in_ready_out), 64'd1);
      bus4.in_valid_in = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      dec_vec("ecall", 32'h0000_0073, F_ECALL, 32'd1);
      dec_vec("ecall_legal", 32'h0000_0073, F_ILLEGAL, 32'd0);
      dec_vec("ebreak", 32'h0010_0073, F_EBREAK, 32'd1);
      dec_vec("mret", 32'h3020_0073, F_MRET, 32'd1);
      dec_vec("wfi_illegal", 32'h1050_0073, F_ILLEGAL, 32'd1);
      dec_vec("lw_size", 32'h0000_2003, F_LSIZE, 32'd2);
      dec_vec("lw_iadder", 32'h0000_2003, F_IADDER, 32'd1);
      dec_vec("lw_wb", 32'h0000_2003, F_WB, 32'd1);
      dec_vec("ld111_illegal", 32'h0000_7003, F_ILLEGAL, 32'd1);
      dec_vec("ld111_rf_wr", 32'h0000_7003, F_RF_WR, 32'd0);
      dec_vec("sub_alu", 32'h4020_8133, F_ALU, 32'h8);
      dec_vec("srai_alu", 32'h4030_D093, F_ALU, 32'hD);
      dec_vec("alt_or_illegal", 32'h4020_E133, F_ILLEGAL, 32'd1);
      dec_vec("csrrw_wr", 32'h3001_10F3, F_CSR_WR, 32'd1);
      dec_vec("csrrw_op", 32'h3001_10F3, F_CSR_OP, 32'd1);
      dec_vec("csrrw_wb", 32'h3001_10F3, F_WB, 32'd4);
      dec_vec("sw_mem_wr", 32'h0020_A023, F_MEM_WR, 32'd1);
      dec_vec("sw_imm", 32'h0020_A023, F_IMM, 32'd2);
      dec_vec("sw_rf_wr", 32'h0020_A023, F_RF_WR, 32'd0);
      dec_vec("fence", 32'h0000_000F, F_FENCE, 32'd1);
      dec_vec("zero_illegal", 32'h0000_0000, F_ILLEGAL, 32'd1);
      dec_vec("br010_illegal", 32'h0000_2063, F_ILLEGAL, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/msrv32_decode_stage.md
# msrv32_decode_stage

Registered, parametrised successor to the msrv32 combinational decoder. Accepts fetched instructions over a valid/ready handshake and decodes them into a packed control bundle. Buffers up to DEPTH decoded entries in an internal queue, adds M-extension and privileged-instruction decode, and supports a single-cycle flush on trap or redirect. Sits between the fetch unit and the execute/register-read stage of the msrv32 pipeline.

## Interface
- DEPTH, 2, queue entries; power of two, ≥2
- M_EXT, 1, 1 = decode RV32M (MUL/DIV family), 0 = treat funct7=0000001 OP as illegal
- ms_riscv32_mp_clk_in  input  1  clock; all state on rising edge
- ms_riscv32_mp_rst_n_in  input  1  asynchronous, active-low reset
- flush_in  input  1  synchronous queue clear (trap_taken or branch redirect)
- in_valid_in  input  1  fetch offers instruction
- in_ready_out  output  1  stage can accept this cycle
- instr_in  input  32  instruction word
- pc_in  input  32  instruction address
- out_valid_out  output  1  head entry valid
- out_ready_in  input  1  downstream consumes head
- bundle_out  output  BUNDLE_W  decoded head entry (layout in package)
- pc_out  output  32  PC of head entry
- count_out  output  $clog2(DEPTH)+1  current occupancy

## Operation
- Decode is combinational on instr_in; the result is written into the queue on push (in_valid_in & in_ready_out & ~flush_in).
- Bundle fields: alu_opcode[3:0], is_muldiv, imm_type[2:0], wb_mux_sel[2:0], rf_wr_en, csr_wr_en, csr_op[2:0], mem_wr_req, load_size[1:0], load_unsigned, alu_src, iadder_src, is_ecall, is_ebreak, is_mret, is_fence, illegal_instr, rd[4:0], rs1[4:0], rs2[4:0].
- Encodings of alu_opcode, imm_type, wb_mux_sel, iadder_src and csr_op are unchanged from the current msrv32 decoder.
- alu_opcode[3] = funct7[5] only for OP and for OP-IMM with funct3=101 (SRAI); it is 0 for all other OP-IMM.
- csr_wr_en = SYSTEM & funct3≠000 & funct3≠100.
- ECALL/EBREAK/MRET decode only on exact 32-bit matches (0x00000073, 0x00100073, 0x30200073).
- illegal_instr is set for any of:
  - opcode[1:0]≠11
  - unlisted opcode
  - OP with funct7 ∉ {0000000, 0100000, 0000001 when M_EXT}
  - 0100000 with funct3 ∉ {000, 101}
  - OP-IMM shift with bad funct7
  - LOAD funct3 ∈ {011, 110, 111}
  - STORE funct3 ≥ 011
  - BRANCH funct3 ∈ {010, 011}
  - SYSTEM funct3=100
  - SYSTEM funct3=000 that is not ECALL/EBREAK/MRET
- An illegal entry forces rf_wr_en, csr_wr_en and mem_wr_req to 0 and is still enqueued; the trap is taken downstream.
- Pop: out_valid_out & out_ready_in.
- Queue implementation: circular buffer with read/write pointers; pointers wrap modulo DEPTH.

## Timing
- Latency: an instruction pushed in cycle N is visible on bundle_out/out_valid_out in cycle N+1 when the queue was empty. There is no combinational input-to-output path.
- in_ready_out = (count < DEPTH), derived from registered state only. Push and pop in the same cycle are allowed when not full.
  - When full, a same-cycle pop does not enable a push.
- Push and pop in the same cycle: count is unchanged.
- flush_in has highest priority: count, pointers and out_valid_out go to 0 next cycle. Any push or pop presented in that cycle is discarded.
- Reset (asynchronous, any time, including mid-transfer):
  - count=0, pointers=0, out_valid_out=0
  - bundle_out=0, pc_out=0, count_out=0
  - in_ready_out=1
- Holding rule: with out_valid_out=1 and out_ready_in=0, bundle_out and pc_out stay stable.

## Structure
- Package msrv32_decode_pkg holds:
  - opcode localparams
  - alu/imm/wb encodings
  - bundle field offsets and BUNDLE_W
  - ECALL/EBREAK/MRET constants
- Sub-module msrv32_instr_decode: purely combinational instr → bundle, parametrised by M_EXT.
- The top level contains only the queue, handshake and flush logic.

## Test plan
- Reset then push ADDI x1,x2,5 (0x00510093) → next cycle out_valid_out=1, alu_opcode=0000, imm_type=001, rf_wr_en=1, illegal_instr=0.
- M_EXT=1, push MUL (0x022081B3) → is_muldiv=1; M_EXT=0, same word → illegal_instr=1, rf_wr_en=0.
- DEPTH=4, out_ready_in=0, push 5 instructions → in_ready_out=0 after 4 pushes, count_out=4, fifth not accepted. Then pop all → PCs emerge in order.
- Continuous push/pop at occupancy 2 for 20 cycles → count_out stays 2, pointers wrap, no loss or duplication.
- Queue holding 3 entries, assert flush_in together with push → next cycle count_out=0, out_valid_out=0, pushed entry dropped.
- Deassert ms_riscv32_mp_rst_n_in mid-stream between clock edges → outputs zero immediately. Push 0x00000073 after release → is_ecall=1; 0x30200073 → is_mret=1; 0x00002003 (LW) → load_size=10, iadder_src=1; 0x00007003 (funct3=111 load) → illegal_instr=1.
